id_ex_stage: RTL
================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 in_valid  in  1  decode slot holds a valid instruction.
REQ-004 in_ready  out  1  stage accepts decode slot this cycle.
REQ-005 in_rs, in_rt, in_rd  in  5 each  source/destination register indices.
REQ-006 in_rdata1, in_rdata2  in  32 each  register-file read data for in_rs/in_rt.
REQ-007 in_imm, in_pc4  in  32 each  sign-extended immediate, PC+4.
REQ-008 in_ctrl  in  8  {RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, RegDst, ALUOp[1:0]}.
REQ-009 wb_we, wb_reg, wb_data  in  1/5/32  write-back port driving the register file this cycle.
REQ-010 flush  in  1  synchronous kill of held and incoming instruction.
REQ-011 out_valid  out  1  held entry valid; out_ready  in  1  execute consumes entry.
REQ-012 out_rs, out_rt, out_rd, out_op1, out_op2, out_imm, out_pc4, out_ctrl  out  registered copies of inputs (out_op1/out_op2 from rdata1/rdata2).
REQ-013 bubble_cnt  out  16  count of load-use bubbles inserted.

Function
REQ-014 Single-entry registered stage; latency from accepted input to out_valid is exactly 1 cycle.
REQ-015 load_use = out_valid & out_ctrl[MemRead] & out_rt!=0 & in_valid & (out_rt==in_rs | out_rt==in_rt).
REQ-016 in_ready = (!out_valid | out_ready) & !load_use & !flush, combinational.
REQ-017 Accept (in_valid & in_ready): all out_* fields load, out_valid=1.
REQ-018 out_valid & out_ready & no accept: out_valid=0 and out_ctrl=0 next cycle.
REQ-019 out_valid & !out_ready: all out_* fields hold except operand update per REQ-022.
REQ-020 load_use & out_ready: held load leaves, bubble inserted (out_valid=0, out_ctrl=0), bubble_cnt+1, saturating at 16'hFFFF; decode instruction accepted the following cycle.
REQ-021 flush: highest priority; out_valid=0, out_ctrl=0 next cycle, no accept, bubble_cnt unchanged.
REQ-022 Held-operand refresh: while out_valid & !accept, wb_we & wb_reg!=0 & wb_reg==out_rs replaces out_op1 (likewise out_rt/out_op2) with wb_data.
REQ-023 Register 0 never bypassed or refreshed; index 0 operands pass in_rdata unchanged.

Reset
REQ-024 rst_n low: out_valid=0, all out_* fields 0, bubble_cnt=0, immediately and independent of clk.
REQ-025 rst_n release: first accept possible on first rising edge with rst_n high; in_ready follows REQ-016.

Configuration
REQ-026 Macro WB_BYPASS_EN defined: on accept, wb_we & wb_reg!=0 & wb_reg==in_rs selects wb_data for out_op1 (same for in_rt/out_op2), covering same-edge register-file write.
REQ-027 WB_BYPASS_EN undefined: operands captured from in_rdata1/in_rdata2 only; REQ-022 refresh still active.

Verification
REQ-028 Reset mid-stream: rst_n low with out_valid=1 -> out_valid=0, bubble_cnt=0 before next edge.
REQ-029 Load then dependent: held lw out_rt=5, in_rs=5, out_ready=1 -> in_ready=0, one bubble, bubble_cnt=1, dependent issued next cycle.
REQ-030 Bypass (WB_BYPASS_EN): in_rs=3, in_rdata1=0x0, wb_we=1, wb_reg=3, wb_data=0xDEADBEEF -> out_op1=0xDEADBEEF; without macro out_op1=0x0.
REQ-031 Stall refresh: out_ready=0, out_rt=7, wb write r7=0x12345678 -> out_op2=0x12345678, other fields unchanged.
REQ-032 Flush with in_valid=1, out_valid=1 -> in_ready=0, next cycle out_valid=0, out_ctrl=0.
REQ-033 r0 guard: wb_reg=0, wb_data=0xFFFFFFFF, in_rs=0, in_rdata1=0 -> out_op1=0x0.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// Decode/execute pipeline bus for id_ex_stage: decode slot, write-back port,
// flush, held execute entry and bubble counter.
interface id_ex_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [31:0] in_rdata1;
  logic [31:0] in_rdata2;
  logic [31:0] in_imm;
  logic [31:0] in_pc4;
  logic [7:0]  in_ctrl;
  logic        wb_we;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_rs;
  logic [4:0]  out_rt;
  logic [4:0]  out_rd;
  logic [31:0] out_op1;
  logic [31:0] out_op2;
  logic [31:0] out_imm;
  logic [31:0] out_pc4;
  logic [7:0]  out_ctrl;
  logic [15:0] bubble_cnt;

  modport master (
    output in_valid, in_rs, in_rt, in_rd, in_rdata1, in_rdata2, in_imm, in_pc4, in_ctrl,
    output wb_we, wb_reg, wb_data, flush, out_ready,
    input  in_ready, out_valid, out_rs, out_rt, out_rd, out_op1, out_op2, out_imm, out_pc4,
    input  out_ctrl, bubble_cnt
  );

  modport slave (
    input  in_valid, in_rs, in_rt, in_rd, in_rdata1, in_rdata2, in_imm, in_pc4, in_ctrl,
    input  wb_we, wb_reg, wb_data, flush, out_ready,
    output in_ready, out_valid, out_rs, out_rt, out_rd, out_op1, out_op2, out_imm, out_pc4,
    output out_ctrl, bubble_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush and held-operand refresh.
// Define WB_BYPASS_EN to forward the same-cycle write-back into operands on accept.
module id_ex_stage (
  input logic          clk,
  input logic          rst_n,
  id_ex_stage_if.slave bus
);
  localparam int unsigned CtrlMemRead = 5;

  logic        valid_q, valid_d;
  logic [4:0]  rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [31:0] op1_q, op1_d, op2_q, op2_d, imm_q, imm_d, pc4_q, pc4_d;
  logic [7:0]  ctrl_q, ctrl_d;
  logic [15:0] bcnt_q, bcnt_d;

  logic        load_use, in_ready, accept;
  logic        wb_hit_out_rs, wb_hit_out_rt;
  logic [31:0] op1_in, op2_in;

  assign load_use = valid_q && ctrl_q[CtrlMemRead] && (rt_q != 5'd0) && bus.in_valid &&
                    ((rt_q == bus.in_rs) || (rt_q == bus.in_rt));
  assign in_ready = (!valid_q || bus.out_ready) && !load_use && !bus.flush;
  assign accept   = bus.in_valid && in_ready;

  assign wb_hit_out_rs = bus.wb_we && (bus.wb_reg != 5'd0) && (bus.wb_reg == rs_q);
  assign wb_hit_out_rt = bus.wb_we && (bus.wb_reg != 5'd0) && (bus.wb_reg == rt_q);

`ifdef WB_BYPASS_EN
  // Register file is written on the same edge we capture, so forward it here.
  logic wb_hit_in_rs, wb_hit_in_rt;
  assign wb_hit_in_rs = bus.wb_we && (bus.wb_reg != 5'd0) && (bus.wb_reg == bus.in_rs);
  assign wb_hit_in_rt = bus.wb_we && (bus.wb_reg != 5'd0) && (bus.wb_reg == bus.in_rt);
  assign op1_in = wb_hit_in_rs ? bus.wb_data : bus.in_rdata1;
  assign op2_in = wb_hit_in_rt ? bus.wb_data : bus.in_rdata2;
`else
  assign op1_in = bus.in_rdata1;
  assign op2_in = bus.in_rdata2;
`endif

  always_comb begin
    valid_d = valid_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    rd_d    = rd_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    imm_d   = imm_q;
    pc4_d   = pc4_q;
    ctrl_d  = ctrl_q;
    bcnt_d  = bcnt_q;
    if (bus.flush) begin
      valid_d = 1'b0;
      ctrl_d  = 8'h00;
    end else if (accept) begin
      valid_d = 1'b1;
      rs_d    = bus.in_rs;
      rt_d    = bus.in_rt;
      rd_d    = bus.in_rd;
      op1_d   = op1_in;
      op2_d   = op2_in;
      imm_d   = bus.in_imm;
      pc4_d   = bus.in_pc4;
      ctrl_d  = bus.in_ctrl;
    end else if (valid_q && bus.out_ready) begin
      valid_d = 1'b0;
      ctrl_d  = 8'h00;
      if (load_use && (bcnt_q != 16'hFFFF)) begin
        bcnt_d = bcnt_q + 16'd1;
      end
    end else if (valid_q) begin
      // Stalled entry: keep operands coherent with the register file.
      if (wb_hit_out_rs) op1_d = bus.wb_data;
      if (wb_hit_out_rt) op2_d = bus.wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      rs_q    <= 5'd0;
      rt_q    <= 5'd0;
      rd_q    <= 5'd0;
      op1_q   <= 32'd0;
      op2_q   <= 32'd0;
      imm_q   <= 32'd0;
      pc4_q   <= 32'd0;
      ctrl_q  <= 8'h00;
      bcnt_q  <= 16'd0;
    end else begin
      valid_q <= valid_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      imm_q   <= imm_d;
      pc4_q   <= pc4_d;
      ctrl_q  <= ctrl_d;
      bcnt_q  <= bcnt_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = valid_q;
  assign bus.out_rs     = rs_q;
  assign bus.out_rt     = rt_q;
  assign bus.out_rd     = rd_q;
  assign bus.out_op1    = op1_q;
  assign bus.out_op2    = op2_q;
  assign bus.out_imm    = imm_q;
  assign bus.out_pc4    = pc4_q;
  assign bus.out_ctrl   = ctrl_q;
  assign bus.bubble_cnt = bcnt_q;
endmodule
